// File: rtl/mem_stage_pkg.sv
// Shared encodings for the MEM stage: funct3 access codes, FSM states and
// width helpers used by mem_stage_hs and mem_lane_align.
package mem_stage_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2,
      ST_HOLD = 2'd3
   } state_e;

   localparam int DW_NARROW = 32;
   localparam int DW_WIDE   = 64;

   function automatic bit dw_legal(input int dw);
      return (dw == DW_NARROW) || (dw == DW_WIDE);
   endfunction

   // Access size in bytes, clamped so 64-bit ops degrade to word on a 32-bit core.
   function automatic int op_bytes(input logic [2:0] op, input int dw);
      int n;
      case (op)
         F3_B, F3_BU: n = 1;
         F3_H, F3_HU: n = 2;
         F3_W, F3_WU: n = 4;
         F3_D:        n = 8;
         default:     n = dw / 8;
      endcase
      if (n > dw / 8) n = dw / 8;
      return n;
   endfunction

   function automatic bit op_signed(input logic [2:0] op);
      return (op != F3_BU) && (op != F3_HU) && (op != F3_WU);
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: store data replication and byte mask, load
// lane extraction with sign/zero extension.
module mem_lane_align
   import mem_stage_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [2:0]                      op,
   input  logic [$clog2(DATA_WIDTH/8)-1:0] lane,
   input  logic [DATA_WIDTH-1:0]           st_data,
   input  logic [DATA_WIDTH-1:0]           rdata,
   output logic [DATA_WIDTH-1:0]           wdata,
   output logic [DATA_WIDTH/8-1:0]         wmask,
   output logic [DATA_WIDTH-1:0]           ld_data
);

   localparam int NB   = DATA_WIDTH / 8;
   localparam int OFFW = $clog2(NB);
   localparam int BW   = $clog2(DATA_WIDTH);

   int                    nbytes;
   logic [OFFW-1:0]       src;
   logic [DATA_WIDTH-1:0] sh;
   logic [BW-1:0]         msb;
   logic                  sign;

   always_comb begin
      nbytes = op_bytes(op, DATA_WIDTH);
      wdata  = '0;
      wmask  = '0;
      src    = '0;
      for (int i = 0; i < NB; i++) begin
         if (i < nbytes) wmask[i] = 1'b1;
         src = OFFW'(i) & OFFW'(nbytes - 1);
         wdata[8*i +: 8] = st_data[{src, 3'b000} +: 8];
      end
      // bytes pushed past the top lane are dropped, never wrapped
      wmask = wmask << lane;

      sh   = rdata >> {lane, 3'b000};
      msb  = BW'(8 * nbytes - 1);
      sign = op_signed(op) && sh[msb];
      for (int b = 0; b < DATA_WIDTH; b++)
         ld_data[b] = (b < 8 * nbytes) ? sh[b] : sign;
   end

endmodule

// File: rtl/mem_stage_hs.sv
// MEM pipeline stage with handshaked data-memory port and EX stall.
// Define MISALIGN_TRAP_EN to add misalign_trap/trap_addr and trap unaligned accesses.
module mem_stage_hs
   import mem_stage_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      ex_valid,
   output logic                      ex_ready,
   input  logic                      flush,
   input  logic                      reg_wee,
   input  logic                      mem_ree,
   input  logic                      mem_wee,
   input  logic [2:0]                ope,
   input  logic [4:0]                rde,
   input  logic [ADDR_WIDTH-1:0]     pcne,
   input  logic [DATA_WIDTH-1:0]     alu_result,
   input  logic [DATA_WIDTH-1:0]     rd2_ture,
   input  logic [1:0]                wb_ctre,
   output logic                      wb_valid,
   output logic                      reg_wem,
   output logic [4:0]                rdm,
   output logic [ADDR_WIDTH-1:0]     pcnm,
   output logic [DATA_WIDTH-1:0]     alu_resultm,
   output logic [1:0]                wb_ctrm,
   output logic [DATA_WIDTH-1:0]     load_datam,
   output logic                      dmem_req,
   output logic                      dmem_we,
   output logic [ADDR_WIDTH-1:0]     dmem_addr,
   output logic [DATA_WIDTH-1:0]     dmem_wdata,
   output logic [DATA_WIDTH/8-1:0]   dmem_wmask,
   input  logic                      dmem_gnt,
   input  logic                      dmem_rvalid,
   input  logic [DATA_WIDTH-1:0]     dmem_rdata
`ifdef MISALIGN_TRAP_EN
   ,
   output logic                      misalign_trap,
   output logic [ADDR_WIDTH-1:0]     trap_addr
`endif
);

   localparam int NB   = DATA_WIDTH / 8;
   localparam int OFFW = $clog2(NB);

   if (!dw_legal(DATA_WIDTH)) begin : g_bad_width
      $error("mem_stage_hs: DATA_WIDTH must be 32 or 64");
   end

   state_e                state_q, state_d;
   logic                  kill_q, kill_d;
   logic                  reg_we_q, reg_we_d;
   logic                  mem_we_q, mem_we_d;
   logic [2:0]            op_q, op_d;
   logic [4:0]            rd_q, rd_d;
   logic [ADDR_WIDTH-1:0] pcn_q, pcn_d;
   logic [DATA_WIDTH-1:0] alu_q, alu_d;
   logic [DATA_WIDTH-1:0] st_data_q, st_data_d;
   logic [1:0]            wb_ctr_q, wb_ctr_d;
   logic [DATA_WIDTH-1:0] load_data_q, load_data_d;

   logic                  cap;
   logic                  misal;
   logic [DATA_WIDTH-1:0] wdata_al, ld_ext;
   logic [NB-1:0]         wmask_al;

   assign cap = ex_valid && ex_ready && !flush;

`ifdef MISALIGN_TRAP_EN
   logic            trap_q, trap_d;
   logic [OFFW-1:0] size_m1;

   always_comb begin
      size_m1 = OFFW'(op_bytes(ope, DATA_WIDTH) - 1);
      misal   = (mem_ree || mem_wee) && ((alu_result[OFFW-1:0] & size_m1) != '0);
      trap_d  = trap_q;
      if (cap) trap_d = misal;
   end

   always_ff @(posedge clk) begin
      if (rst) trap_q <= 1'b0;
      else     trap_q <= trap_d;
   end

   assign misalign_trap = (state_q == ST_HOLD) && trap_q;
   assign trap_addr     = misalign_trap ? ADDR_WIDTH'(alu_q) : '0;
`else
   assign misal = 1'b0;
`endif

   mem_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
      .op      (op_q),
      .lane    (alu_q[OFFW-1:0]),
      .st_data (st_data_q),
      .rdata   (dmem_rdata),
      .wdata   (wdata_al),
      .wmask   (wmask_al),
      .ld_data (ld_ext)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      kill_d  = kill_q;
      case (state_q)
         ST_IDLE, ST_HOLD: begin
            state_d = ST_IDLE;
            kill_d  = 1'b0;
            if (cap) state_d = ((mem_ree || mem_wee) && !misal) ? ST_REQ : ST_HOLD;
         end
         ST_REQ: begin
            if (flush) begin
               // a load granted in the flush cycle still owes a response; drain it
               state_d = (dmem_gnt && !mem_we_q) ? ST_RESP : ST_IDLE;
               kill_d  = dmem_gnt && !mem_we_q;
            end else if (dmem_gnt) begin
               state_d = mem_we_q ? ST_HOLD : ST_RESP;
            end
         end
         ST_RESP: begin
            if (dmem_rvalid) begin
               state_d = (kill_q || flush) ? ST_IDLE : ST_HOLD;
               kill_d  = 1'b0;
            end else if (flush) begin
               kill_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      ex_ready   = (state_q == ST_IDLE) || (state_q == ST_HOLD);
      wb_valid   = (state_q == ST_HOLD);
      dmem_req   = (state_q == ST_REQ);
      dmem_we    = dmem_req && mem_we_q;
      dmem_addr  = '0;
      dmem_wdata = '0;
      dmem_wmask = '0;
      if (dmem_req) begin
         dmem_addr = ADDR_WIDTH'(alu_q) & ~ADDR_WIDTH'(NB - 1);
         if (mem_we_q) begin
            dmem_wdata = wdata_al;
            dmem_wmask = wmask_al;
         end
      end
   end

   always_comb begin
      reg_we_d    = reg_we_q;
      mem_we_d    = mem_we_q;
      op_d        = op_q;
      rd_d        = rd_q;
      pcn_d       = pcn_q;
      alu_d       = alu_q;
      st_data_d   = st_data_q;
      wb_ctr_d    = wb_ctr_q;
      load_data_d = load_data_q;
      if (cap) begin
         reg_we_d  = reg_wee && !misal;
         mem_we_d  = mem_wee;
         op_d      = ope;
         rd_d      = rde;
         pcn_d     = pcne;
         alu_d     = alu_result;
         st_data_d = rd2_ture;
         wb_ctr_d  = wb_ctre;
      end
      if ((state_q == ST_RESP) && dmem_rvalid && !kill_q && !flush)
         load_data_d = ld_ext;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         kill_q      <= 1'b0;
         reg_we_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         op_q        <= '0;
         rd_q        <= '0;
         pcn_q       <= '0;
         alu_q       <= '0;
         st_data_q   <= '0;
         wb_ctr_q    <= '0;
         load_data_q <= '0;
      end else begin
         kill_q      <= kill_d;
         reg_we_q    <= reg_we_d;
         mem_we_q    <= mem_we_d;
         op_q        <= op_d;
         rd_q        <= rd_d;
         pcn_q       <= pcn_d;
         alu_q       <= alu_d;
         st_data_q   <= st_data_d;
         wb_ctr_q    <= wb_ctr_d;
         load_data_q <= load_data_d;
      end
   end

   assign reg_wem     = reg_we_q;
   assign rdm         = rd_q;
   assign pcnm        = pcn_q;
   assign alu_resultm = alu_q;
   assign wb_ctrm     = wb_ctr_q;
   assign load_datam  = load_data_q;

endmodule
